vt52_cmd_encoder: RTL and testbench

Host-side counterpart of the VT52-like terminal. Converts high-level display commands (put char, cursor goto, clear, erase line, newline, bell, graphics mode, reverse LF) into the VT52 byte sequences the terminal decodes. Bytes go out over a valid/ready stream to the uart1402 transmit holding register via a small adapter, or into a loopback bench. One command is in flight at a time.

---
 rtl/vt52_cmd_encoder_if.sv | 25 ++
 rtl/vt52_cmd_encoder.sv | 150 +++++++++++++++
 tb/tb_vt52_cmd_encoder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vt52_cmd_encoder_if.sv
// Command and byte-stream bundle between a VT52 command source and the encoder.
// A transfer on either stream happens on a rising clock54 edge where valid and ready are
// both high; once valid is raised, the producer holds valid and its payload until that edge.
interface vt52_cmd_encoder_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [6:0] cmd_char;
    logic [4:0] cmd_row;
    logic [6:0] cmd_col;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_char, cmd_row, cmd_col, tx_ready,
        input  cmd_ready, tx_valid, tx_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_char, cmd_row, cmd_col, tx_ready,
        output cmd_ready, tx_valid, tx_data, busy
    );
endinterface

// File: rtl/vt52_cmd_encoder.sv
// Turns one high-level display command at a time into its VT52 byte sequence,
// presented one byte per handshake on the tx stream.
module vt52_cmd_encoder #(
    parameter int unsigned FILL_AFTER_CLEAR = 0,
    parameter int unsigned ROWS             = 24,
    parameter int unsigned COLS             = 80
) (
    input  logic                clock54,
    input  logic                reset,
    vt52_cmd_encoder_if.slave   bus,
    output logic                dbg_state_o,
    output logic [4:0]          dbg_index_o
);
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [2:0] OP_PUTC    = 3'd0;
    localparam logic [2:0] OP_GOTO    = 3'd1;
    localparam logic [2:0] OP_CLEAR   = 3'd2;
    localparam logic [2:0] OP_EOL     = 3'd3;
    localparam logic [2:0] OP_NEWLINE = 3'd4;
    localparam logic [2:0] OP_BELL    = 3'd5;
    localparam logic [2:0] OP_GRAPH   = 3'd6;
    localparam logic [2:0] OP_REVLF   = 3'd7;

    localparam logic [4:0] ROW_MAX  = 5'(ROWS - 1);
    localparam logic [6:0] COL_MAX  = 7'(COLS - 1);
    localparam logic [4:0] FILL_LEN = 5'(FILL_AFTER_CLEAR);

    state_t     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [4:0] len_q, len_d;
    logic [2:0] op_q, op_d;
    logic [6:0] char_q, char_d;
    logic [4:0] row_q, row_d;
    logic [6:0] col_q, col_d;

    logic [4:0] row_clamp;
    logic [6:0] col_clamp;
    logic [4:0] cmd_len;
    logic [6:0] seq_byte;

    // Clamping happens here so the stored coordinates are always on-screen.
    assign row_clamp = (bus.cmd_row > ROW_MAX) ? ROW_MAX : bus.cmd_row;
    assign col_clamp = (bus.cmd_col > COL_MAX) ? COL_MAX : bus.cmd_col;

    always_comb begin
        cmd_len = 5'd2;
        case (bus.cmd_op)
            OP_PUTC, OP_BELL: cmd_len = 5'd1;
            OP_GOTO:          cmd_len = 5'd4;
            OP_CLEAR:         cmd_len = 5'd4 + FILL_LEN;
            default:          cmd_len = 5'd2;
        endcase
    end

    always_comb begin
        seq_byte = 7'h00;
        case (op_q)
            OP_PUTC: seq_byte = char_q;
            OP_GOTO: begin
                case (idx_q)
                    5'd0:    seq_byte = 7'h1B;
                    5'd1:    seq_byte = 7'h59;
                    5'd2:    seq_byte = 7'h20 + {2'b00, row_q};
                    default: seq_byte = 7'h20 + col_q;
                endcase
            end
            OP_CLEAR: begin
                case (idx_q)
                    5'd0:    seq_byte = 7'h1B;
                    5'd1:    seq_byte = 7'h48;
                    5'd2:    seq_byte = 7'h1B;
                    5'd3:    seq_byte = 7'h4A;
                    default: seq_byte = 7'h00;
                endcase
            end
            OP_EOL:     seq_byte = (idx_q == 5'd0) ? 7'h1B : 7'h4B;
            OP_NEWLINE: seq_byte = (idx_q == 5'd0) ? 7'h0D : 7'h0A;
            OP_BELL:    seq_byte = 7'h07;
            OP_GRAPH:   seq_byte = (idx_q == 5'd0) ? 7'h1B : (char_q[0] ? 7'h46 : 7'h47);
            OP_REVLF:   seq_byte = (idx_q == 5'd0) ? 7'h1B : 7'h49;
            default:    seq_byte = 7'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        op_d    = op_q;
        char_d  = char_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    char_d  = bus.cmd_char;
                    row_d   = row_clamp;
                    col_d   = col_clamp;
                    len_d   = cmd_len;
                    idx_d   = 5'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.tx_ready) begin
                    if (idx_q == len_q - 5'd1) begin
                        idx_d   = 5'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock54) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            len_q   <= 5'd0;
            op_q    <= 3'd0;
            char_q  <= 7'd0;
            row_q   <= 5'd0;
            col_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            op_q    <= op_d;
            char_q  <= char_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Outputs come straight from registered state, so they hold steady while stalled.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.tx_valid  = (state_q == SEND);
    assign bus.tx_data   = (state_q == SEND) ? {1'b0, seq_byte} : 8'h00;
    assign dbg_state_o   = logic'(state_q);
    assign dbg_index_o   = idx_q;
endmodule

// File: tb/tb_vt52_cmd_encoder.sv
// Directed plus lightly randomised bench for vt52_cmd_encoder with a byte scoreboard.
module tb_vt52_cmd_encoder;
    localparam int FILL = 2;

    logic clock54 = 1'b0;
    logic reset   = 1'b1;
    always #9 clock54 = ~clock54;

    vt52_cmd_encoder_if bus();
    vt52_cmd_encoder_if bus0();

    logic       dbg_state, dbg_state0;
    logic [4:0] dbg_idx, dbg_idx0;

    vt52_cmd_encoder #(.FILL_AFTER_CLEAR(FILL), .ROWS(24), .COLS(80)) dut (
        .clock54(clock54), .reset(reset), .bus(bus),
        .dbg_state_o(dbg_state), .dbg_index_o(dbg_idx)
    );

    vt52_cmd_encoder #(.FILL_AFTER_CLEAR(0), .ROWS(24), .COLS(80)) dut0 (
        .clock54(clock54), .reset(reset), .bus(bus0),
        .dbg_state_o(dbg_state0), .dbg_index_o(dbg_idx0)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp0_q[$];
    logic [7:0] model_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check(tag, {7'b0, obs}, {7'b0, exp});
    endtask

    task automatic step();
        @(posedge clock54);
        #1;
    endtask

    // Reference byte sequence for a command, built into model_q.
    function automatic void model(input logic [2:0] op, input logic [6:0] ch,
                                  input logic [4:0] row, input logic [6:0] col, input int fill);
        int r;
        int c;
        r = (int'(row) > 23) ? 23 : int'(row);
        c = (int'(col) > 79) ? 79 : int'(col);
        model_q.delete();
        case (op)
            3'd0: model_q.push_back({1'b0, ch});
            3'd1: begin
                model_q.push_back(8'h1B); model_q.push_back(8'h59);
                model_q.push_back(8'(32 + r)); model_q.push_back(8'(32 + c));
            end
            3'd2: begin
                model_q.push_back(8'h1B); model_q.push_back(8'h48);
                model_q.push_back(8'h1B); model_q.push_back(8'h4A);
                for (int k = 0; k < fill; k++) model_q.push_back(8'h00);
            end
            3'd3: begin model_q.push_back(8'h1B); model_q.push_back(8'h4B); end
            3'd4: begin model_q.push_back(8'h0D); model_q.push_back(8'h0A); end
            3'd5: model_q.push_back(8'h07);
            3'd6: begin model_q.push_back(8'h1B); model_q.push_back(ch[0] ? 8'h46 : 8'h47); end
            default: begin model_q.push_back(8'h1B); model_q.push_back(8'h49); end
        endcase
    endfunction

    // Scoreboard for the main instance: every handshake pops one expected byte.
    always @(negedge clock54) begin
        if (!reset && bus.tx_valid && bus.tx_ready) begin
            check1("byte_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("tx_byte", bus.tx_data, exp_q.pop_front());
        end
    end

    always @(negedge clock54) begin
        if (!reset && bus0.tx_valid && bus0.tx_ready) begin
            check1("byte0_expected", exp0_q.size() != 0, 1'b1);
            if (exp0_q.size() != 0) check("tx0_byte", bus0.tx_data, exp0_q.pop_front());
        end
    end

    // A stalled byte must still be offered, unchanged, on the next cycle.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clock54) begin
        if (!reset && prev_stall) begin
            check1("hold_valid", bus.tx_valid, 1'b1);
            check("hold_data", bus.tx_data, prev_data);
        end
        prev_stall = !reset && bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
    end

    task automatic send_cmd(input logic [2:0] op, input logic [6:0] ch,
                            input logic [4:0] row, input logic [6:0] col);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin step(); n++; end
        check1("accept_ready", bus.cmd_ready, 1'b1);
        bus.cmd_op    = op;
        bus.cmd_char  = ch;
        bus.cmd_row   = row;
        bus.cmd_col   = col;
        bus.cmd_valid = 1'b1;
        model(op, ch, row, col, FILL);
        foreach (model_q[k]) exp_q.push_back(model_q[k]);
        step();
        bus.cmd_valid = 1'b0;
        check1("first_valid", bus.tx_valid, 1'b1);
    endtask

    task automatic wait_idle(input int budget, input bit rnd, output int cycles);
        cycles = 0;
        while (!bus.cmd_ready && cycles < budget) begin
            if (rnd) bus.tx_ready = 1'($urandom_range(0, 1));
            step();
            cycles++;
        end
        check1("idle_reached", bus.cmd_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_char = 7'd0;
        bus.cmd_row = 5'd0; bus.cmd_col = 7'd0; bus.tx_ready = 1'b0;
        bus0.cmd_valid = 1'b0; bus0.cmd_op = 3'd2; bus0.cmd_char = 7'd0;
        bus0.cmd_row = 5'd0; bus0.cmd_col = 7'd0; bus0.tx_ready = 1'b1;

        reset = 1'b1;
        repeat (3) step();
        check1("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check1("rst_tx_valid", bus.tx_valid, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_state", dbg_state, 1'b0);
        check("rst_index", {3'b0, dbg_idx}, 8'h00);
        reset = 1'b0;
        step();

        // GOTO 5,10 with the sink always ready: four consecutive bytes
        bus.tx_ready = 1'b1;
        send_cmd(3'd1, 7'd0, 5'd5, 7'd10);
        check("goto_b0", bus.tx_data, 8'h1B);
        check1("goto_busy", bus.busy, 1'b1);
        step(); check("goto_b1", bus.tx_data, 8'h59);
        step(); check("goto_b2", bus.tx_data, 8'h25);
        step(); check("goto_b3", bus.tx_data, 8'h2A);
        check1("goto_b3_valid", bus.tx_valid, 1'b1);
        step();
        check1("goto_done_valid", bus.tx_valid, 1'b0);
        check1("goto_done_ready", bus.cmd_ready, 1'b1);
        check1("goto_done_busy", bus.busy, 1'b0);

        // Clamped GOTO; inputs changed after accept must not matter
        send_cmd(3'd1, 7'd0, 5'd30, 7'd100);
        bus.cmd_row = 5'd3; bus.cmd_col = 7'd4;
        wait_idle(50, 1'b0, n);
        check("goto_clamp_len", 8'(n), 8'd4);

        // CLEAR with two fill bytes: six byte cycles
        send_cmd(3'd2, 7'd0, 5'd0, 7'd0);
        wait_idle(50, 1'b0, n);
        check("clear_fill2_len", 8'(n), 8'd6);

        // PUTC 'A' stalled for three cycles
        bus.tx_ready = 1'b0;
        send_cmd(3'd0, 7'h41, 5'd0, 7'd0);
        check("putc_stall0", bus.tx_data, 8'h41);
        step(); check("putc_stall1", bus.tx_data, 8'h41); check1("putc_stall1_v", bus.tx_valid, 1'b1);
        step(); check("putc_stall2", bus.tx_data, 8'h41); check1("putc_stall2_v", bus.tx_valid, 1'b1);
        bus.tx_ready = 1'b1;
        step();
        check1("putc_done_valid", bus.tx_valid, 1'b0);
        check1("putc_done_ready", bus.cmd_ready, 1'b1);

        // GRAPH on/off, BELL, PUTC 0x7F
        send_cmd(3'd6, 7'h01, 5'd0, 7'd0);
        check("graph_on_b0", bus.tx_data, 8'h1B);
        step(); check("graph_on_b1", bus.tx_data, 8'h46);
        wait_idle(50, 1'b0, n);
        send_cmd(3'd6, 7'h00, 5'd0, 7'd0);
        wait_idle(50, 1'b0, n);
        send_cmd(3'd5, 7'h00, 5'd0, 7'd0);
        check("bell_b0", bus.tx_data, 8'h07);
        wait_idle(50, 1'b0, n);
        check("bell_len", 8'(n), 8'd1);
        send_cmd(3'd0, 7'h7F, 5'd0, 7'd0);
        wait_idle(50, 1'b0, n);

        // NEWLINE with a second request pulsed while busy
        bus.tx_ready = 1'b0;
        send_cmd(3'd4, 7'h00, 5'd0, 7'd0);
        bus.cmd_op = 3'd5; bus.cmd_valid = 1'b1;
        check1("busy_not_ready", bus.cmd_ready, 1'b0);
        step();
        bus.cmd_valid = 1'b0;
        wait_idle(200, 1'b1, n);
        repeat (3) step();
        check("busy_pulse_ignored", 8'(exp_q.size()), 8'd0);

        // Random commands under random back-pressure
        for (int i = 0; i < 8; i++) begin
            send_cmd(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                     5'($urandom_range(0, 31)), 7'($urandom_range(0, 127)));
            wait_idle(200, 1'b1, n);
        end

        // Reset after the second GOTO byte, then CLEAR
        bus.tx_ready = 1'b1;
        send_cmd(3'd1, 7'd0, 5'd2, 7'd2);
        step();
        step();
        bus.tx_ready = 1'b0;
        reset = 1'b1;
        step();
        exp_q.delete();
        step();
        reset = 1'b0;
        step();
        check1("abort_tx_valid", bus.tx_valid, 1'b0);
        check1("abort_cmd_ready", bus.cmd_ready, 1'b1);
        bus.tx_ready = 1'b1;
        send_cmd(3'd2, 7'd0, 5'd0, 7'd0);
        check("post_reset_b0", bus.tx_data, 8'h1B);
        step(); check("post_reset_b1", bus.tx_data, 8'h48);
        wait_idle(50, 1'b0, n);

        // Instance without fill: CLEAR is exactly four bytes
        model(3'd2, 7'd0, 5'd0, 7'd0, 0);
        foreach (model_q[k]) exp0_q.push_back(model_q[k]);
        check1("fill0_ready", bus0.cmd_ready, 1'b1);
        bus0.cmd_valid = 1'b1;
        step();
        bus0.cmd_valid = 1'b0;
        n = 0;
        while (!bus0.cmd_ready && n < 50) begin step(); n++; end
        check("clear_fill0_len", 8'(n), 8'd4);

        step();
        check("main_queue_drained", 8'(exp_q.size()), 8'd0);
        check("fill0_queue_drained", 8'(exp0_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
